// File: rtl/demux_1_4_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer.
// It carries the data/select inputs and the routed outputs with their error flag.
interface demux_1_4_if;
    logic       i_a;
    logic [3:0] i_sel_code;
    logic       o_a;
    logic       o_b;
    logic       o_c;
    logic       o_d;
    logic       o_sel_err;

    modport master (
        output i_a,
        output i_sel_code,
        input  o_a,
        input  o_b,
        input  o_c,
        input  o_d,
        input  o_sel_err
    );

    modport slave (
        input  i_a,
        input  i_sel_code,
        output o_a,
        output o_b,
        output o_c,
        output o_d,
        output o_sel_err
    );
endinterface

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demultiplexer with a one-hot select code.
// A select code that is not one-hot clears every output and raises a one-cycle error flag.
module demux_1_4 (
    input  logic          i_clk,
    input  logic          i_rst_n,
    demux_1_4_if.slave    bus
);

    logic a_s, b_s, c_s, d_s, sel_err_s;
    logic a_r, b_r, c_r, d_r, sel_err_r;

    // Next-state decode: route the data bit only for exact one-hot codes.
    always_comb begin
        a_s       = 1'b0;
        b_s       = 1'b0;
        c_s       = 1'b0;
        d_s       = 1'b0;
        sel_err_s = 1'b0;
        case (bus.i_sel_code)
            4'b0001: a_s       = bus.i_a;
            4'b0010: b_s       = bus.i_a;
            4'b0100: c_s       = bus.i_a;
            4'b1000: d_s       = bus.i_a;
            default: sel_err_s = 1'b1;
        endcase
    end

    // Output registers with synchronous active-low reset taking priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            c_r       <= 1'b0;
            d_r       <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            a_r       <= a_s;
            b_r       <= b_s;
            c_r       <= c_s;
            d_r       <= d_s;
            sel_err_r <= sel_err_s;
        end
    end

    assign bus.o_a       = a_r;
    assign bus.o_b       = b_r;
    assign bus.o_c       = c_r;
    assign bus.o_d       = d_r;
    assign bus.o_sel_err = sel_err_r;

endmodule

// File: tb/tb_demux_1_4.sv
// Directed self-checking bench for demux_1_4.
// Observed outputs are packed as {o_d, o_c, o_b, o_a, o_sel_err}.
module tb_demux_1_4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux_1_4_if bus ();

    demux_1_4 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then compare 1 time unit later.
    task automatic apply(input string tag, input logic rst_v, input logic a_v,
                         input logic [3:0] sel_v, input logic [4:0] exp);
        rst_n          = rst_v;
        bus.i_a        = a_v;
        bus.i_sel_code = sel_v;
        @(posedge clk);
        #1;
        check_val(tag, {bus.o_d, bus.o_c, bus.o_b, bus.o_a, bus.o_sel_err}, exp);
    endtask

    // Hand-written rule: one-hot -> route i_a to that lane, else all lanes 0 and error.
    function automatic logic [4:0] rule(input logic a_v, input logic [3:0] sel_v);
        logic [4:0] r;
        case (sel_v)
            4'b0001: r = {3'b000, a_v, 1'b0};
            4'b0010: r = {2'b00, a_v, 2'b00};
            4'b0100: r = {1'b0, a_v, 3'b000};
            4'b1000: r = {a_v, 4'b0000};
            default: r = 5'b00001;
        endcase
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Reset held for two edges with an active route requested.
        apply("reset_0", 1'b0, 1'b1, 4'b0001, 5'b00000);
        apply("reset_1", 1'b0, 1'b1, 4'b0001, 5'b00000);

        // Valid routing with i_a = 1, then i_a = 0.
        apply("route_a1", 1'b1, 1'b1, 4'b0001, 5'b00010);
        apply("route_b1", 1'b1, 1'b1, 4'b0010, 5'b00100);
        apply("route_c1", 1'b1, 1'b1, 4'b0100, 5'b01000);
        apply("route_d1", 1'b1, 1'b1, 4'b1000, 5'b10000);
        apply("route_a0", 1'b1, 1'b0, 4'b0001, 5'b00000);
        apply("route_b0", 1'b1, 1'b0, 4'b0010, 5'b00000);
        apply("route_c0", 1'b1, 1'b0, 4'b0100, 5'b00000);
        apply("route_d0", 1'b1, 1'b0, 4'b1000, 5'b00000);

        // Directed invalid codes.
        apply("bad_0000", 1'b1, 1'b1, 4'b0000, 5'b00001);
        apply("bad_0011", 1'b1, 1'b1, 4'b0011, 5'b00001);
        apply("bad_1111", 1'b1, 1'b1, 4'b1111, 5'b00001);

        // Exhaustive sweep of {i_a, i_sel_code}.
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vec;
            vec = v[4:0];
            apply($sformatf("sweep_%0d", v), 1'b1, vec[4], vec[3:0], rule(vec[4], vec[3:0]));
        end

        // Error flag clears on the first valid select.
        apply("recov_err", 1'b1, 1'b1, 4'b0110, 5'b00001);
        apply("recov_ok",  1'b1, 1'b1, 4'b0100, 5'b01000);

        // Reset in the middle of an active route, then release.
        apply("mid_set",     1'b1, 1'b1, 4'b0010, 5'b00100);
        apply("mid_reset",   1'b0, 1'b1, 4'b0010, 5'b00000);
        apply("mid_release", 1'b1, 1'b1, 4'b0010, 5'b00100);

        // Outputs hold between edges: sample again just before the next edge.
        #3;
        check_val("hold", {bus.o_d, bus.o_c, bus.o_b, bus.o_a, bus.o_sel_err}, 5'b00100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_4.md
Name: demux_1_4

Overview:
- Registered 1-to-4 demultiplexer: routes the single data bit i_a to one of four outputs, chosen by a 4-bit one-hot select code.
- Unselected outputs are driven 0.
- Used as a datapath steering component; its outputs are registered on the system clock with a synchronous active-low reset.
- Select codes that are not one-hot are rejected: all outputs go 0 and an error flag is raised.

Parameters:
- None.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_a  input  1  data bit to be routed
- i_sel_code  input  4  one-hot select; bit0→o_a, bit1→o_b, bit2→o_c, bit3→o_d
- o_a  output  1  registered copy of i_a when i_sel_code = 4'b0001, else 0
- o_b  output  1  registered copy of i_a when i_sel_code = 4'b0010, else 0
- o_c  output  1  registered copy of i_a when i_sel_code = 4'b0100, else 0
- o_d  output  1  registered copy of i_a when i_sel_code = 4'b1000, else 0
- o_sel_err  output  1  registered flag, 1 when the sampled i_sel_code was not one-hot

Behaviour:
- Interface: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
- All outputs are flip-flops updated only on the rising edge of i_clk. No combinational path from inputs to outputs.
- Reset:
  - i_rst_n = 0 sampled at a rising edge → o_a = o_b = o_c = o_d = 0 and o_sel_err = 0 after that edge.
  - Reset takes priority over all other inputs.
  - Asserting reset mid-operation clears outputs at the next edge, regardless of i_a or i_sel_code.
- Latency: exactly 1 cycle. Values of i_a and i_sel_code sampled at edge N appear on the outputs after edge N. Outputs hold between edges.
- Valid select (exactly one bit set):
  - The selected output equals sampled i_a.
  - The other three outputs are 0.
  - o_sel_err = 0.
- Invalid select (4'b0000, or two or more bits set):
  - o_a = o_b = o_c = o_d = 0 regardless of i_a.
  - o_sel_err = 1.
- Invariant: at most one of o_a..o_d is 1 at any time.
- Outputs are fully recomputed every cycle. There is no sticky state: o_sel_err clears on the first cycle with a valid select.
- X/Z on inputs: no defined behaviour required. Implementation must not latch.
- Before the first reset, output values are don't-care.

Test Plan:
- Reset: hold i_rst_n = 0 for 2 edges with i_a = 1, i_sel_code = 4'b0001 → all outputs 0, o_sel_err = 0.
- Valid routing: release reset; i_a = 1, apply sel 4'b0001, 4'b0010, 4'b0100, 4'b1000 on successive cycles → o_a, o_b, o_c, o_d respectively go 1 one cycle later, others 0, o_sel_err = 0. Repeat with i_a = 0 → all outputs 0, o_sel_err = 0.
- Exhaustive sweep: iterate the 5-bit vector {i_a, i_sel_code} from 0 to 31, one value per cycle → each cycle's outputs match the rules for the previous cycle's inputs. Non-one-hot codes (e.g. 4'b0000, 4'b0011, 4'b1111) give all outputs 0 and o_sel_err = 1.
- Error recovery: sel 4'b0110, i_a = 1 → o_sel_err = 1, outputs 0. Next cycle sel 4'b0100 → o_c = 1, o_sel_err = 0.
- Reset mid-operation: with o_b = 1 (sel 4'b0010, i_a = 1), drive i_rst_n = 0 for one edge → all outputs 0 after that edge. Release → o_b = 1 again one edge later.
